word_align_param: RTL

WORD_ALIGN_PARAM -- requirements
Module: word_align_param

---
 rtl/word_align_pkg.sv | 22 ++
 rtl/word_align_if.sv | 30 +++
 rtl/word_align_match.sv | 16 +
 rtl/word_align_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/word_align_pkg.sv
// Shared types and constants for the word aligner.
// State encoding, default marker pattern and small helpers.
package word_align_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_PAT_MASK  = 32'hC001C001;
    localparam logic [31:0] DEF_PAT_VALUE = 32'h80004000;

    function automatic int off_w(input int din_w);
        return (din_w > 1) ? $clog2(din_w) : 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/word_align_if.sv
// Serial-in / aligned-word-out bundle of the word aligner.
// slave = aligner side, master = source/sink side.
interface word_align_if #(
    parameter int DIN_W  = 2,
    parameter int WORD_W = 32,
    parameter int OFF_W  = word_align_pkg::off_w(DIN_W)
);
    logic [DIN_W-1:0]  i_ddr_data;
    logic              i_resync;
    logic              i_fifo_full;
    logic              o_fifo_push;
    logic [WORD_W-1:0] o_fifo_data;
    logic              o_locked;
    logic [OFF_W-1:0]  o_offset;
    logic              o_lock_lost;
    logic              o_ovf;
    logic [7:0]        o_err_count;

    modport slave (
        input  i_ddr_data, i_resync, i_fifo_full,
        output o_fifo_push, o_fifo_data, o_locked,
        output o_offset, o_lock_lost, o_ovf, o_err_count
    );

    modport master (
        output i_ddr_data, i_resync, i_fifo_full,
        input  o_fifo_push, o_fifo_data, o_locked,
        input  o_offset, o_lock_lost, o_ovf, o_err_count
    );
endinterface

// File: rtl/word_align_match.sv
// Word classifier: marker match (real) and tolerated idle (zero).
module word_align_match
    import word_align_pkg::*;
#(
    parameter int                WORD_W     = 32,
    parameter logic [WORD_W-1:0] PAT_MASK   = WORD_W'(DEF_PAT_MASK),
    parameter logic [WORD_W-1:0] PAT_VALUE  = WORD_W'(DEF_PAT_VALUE),
    parameter int                ALLOW_ZERO = 1
) (
    input  logic [WORD_W-1:0] word,
    output logic              is_real,
    output logic              is_zero
);
    assign is_real = (word & PAT_MASK) == PAT_VALUE;
    assign is_zero = (ALLOW_ZERO != 0) && (word == '0);
endmodule

// File: rtl/word_align_param.sv
// Bit-offset word aligner: searches all offsets for the marker,
// confirms it on later words, then pushes aligned words downstream.
module word_align_param
    import word_align_pkg::*;
#(
    parameter int                DIN_W           = 2,
    parameter int                WORD_W          = 32,
    parameter logic [WORD_W-1:0] PAT_MASK        = WORD_W'(DEF_PAT_MASK),
    parameter logic [WORD_W-1:0] PAT_VALUE       = WORD_W'(DEF_PAT_VALUE),
    parameter int                MATCH_THRESHOLD = 2,
    parameter int                MISS_LIMIT      = 1,
    parameter int                ALLOW_ZERO      = 1
) (
    input  logic         i_ddr_clk,
    input  logic         i_rst_b,
    word_align_if.slave  bus
);
    localparam int SR_W  = WORD_W + DIN_W - 1;
    localparam int N     = WORD_W / DIN_W;
    localparam int PH_W  = (N > 1) ? $clog2(N) : 1;
    localparam int OFF_W = off_w(DIN_W);
    localparam logic [3:0] MATCH_LAST = 4'(MATCH_THRESHOLD - 1);
    localparam logic [3:0] MISS_LAST  = 4'(MISS_LIMIT - 1);

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [PH_W-1:0]   phase;
    logic [OFF_W-1:0]  off;
    logic [3:0]        match_cnt;
    logic [3:0]        miss_cnt;
    logic [7:0]        err_cnt;
    logic              push_q;
    logic [WORD_W-1:0] data_q;
    logic              lost_q;
    logic              ovf_q;

    logic [DIN_W-1:0]  hit_real;
    logic [DIN_W-1:0]  zero_unused;
    logic              hit_any;
    logic [OFF_W-1:0]  hit_k;
    logic [WORD_W-1:0] cand;
    logic              cand_real;
    logic              cand_zero;
    logic              at_end;
    logic [PH_W-1:0]   ph_nxt;

    for (genvar k = 0; k < DIN_W; k++) begin : g_off
        word_align_match #(
            .WORD_W(WORD_W), .PAT_MASK(PAT_MASK),
            .PAT_VALUE(PAT_VALUE), .ALLOW_ZERO(ALLOW_ZERO)
        ) u_match (
            .word(sr[WORD_W-1+k:k]),
            .is_real(hit_real[k]),
            .is_zero(zero_unused[k])
        );
    end

    // Scan downwards so the lowest real offset is the last one written.
    always_comb begin
        hit_any = 1'b0;
        hit_k   = '0;
        for (int k = DIN_W - 1; k >= 0; k--) begin
            if (hit_real[k]) begin
                hit_any = 1'b1;
                hit_k   = OFF_W'(k);
            end
        end
    end

    assign cand = sr[off +: WORD_W];

    word_align_match #(
        .WORD_W(WORD_W), .PAT_MASK(PAT_MASK),
        .PAT_VALUE(PAT_VALUE), .ALLOW_ZERO(ALLOW_ZERO)
    ) u_sel (
        .word(cand),
        .is_real(cand_real),
        .is_zero(cand_zero)
    );

    assign at_end = (phase == PH_W'(N - 1));
    assign ph_nxt = at_end ? '0 : phase + 1'b1;

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sr        <= '0;
            state     <= SEARCH;
            phase     <= '0;
            off       <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
            push_q    <= 1'b0;
            data_q    <= '0;
            lost_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sr     <= {sr[SR_W-DIN_W-1:0], bus.i_ddr_data};
            push_q <= 1'b0;
            lost_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (bus.i_resync) begin
                state     <= SEARCH;
                phase     <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                lost_q    <= (state == LOCKED);
            end else begin
                case (state)
                    SEARCH: begin
                        if (hit_any) begin
                            off       <= hit_k;
                            phase     <= '0;
                            match_cnt <= '0;
                            state     <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        phase <= ph_nxt;
                        if (at_end) begin
                            if (cand_real) begin
                                match_cnt <= match_cnt + 4'd1;
                                if (match_cnt == MATCH_LAST) begin
                                    state    <= LOCKED;
                                    miss_cnt <= '0;
                                end
                            end else if (!cand_zero) begin
                                state   <= SEARCH;
                                err_cnt <= sat_inc(err_cnt);
                            end
                        end
                    end
                    LOCKED: begin
                        phase <= ph_nxt;
                        if (at_end) begin
                            if (cand_real) begin
                                miss_cnt <= '0;
                                if (bus.i_fifo_full) begin
                                    ovf_q <= 1'b1;
                                end else begin
                                    push_q <= 1'b1;
                                    data_q <= cand;
                                end
                            end else if (!cand_zero) begin
                                err_cnt <= sat_inc(err_cnt);
                                if (miss_cnt == MISS_LAST) begin
                                    state    <= SEARCH;
                                    miss_cnt <= '0;
                                    lost_q   <= 1'b1;
                                end else begin
                                    miss_cnt <= miss_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.o_fifo_push = push_q;
    assign bus.o_fifo_data = data_q;
    assign bus.o_locked    = (state == LOCKED);
    assign bus.o_offset    = off;
    assign bus.o_lock_lost = lost_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_err_count = err_cnt;

endmodule
